// File: rtl/waveform_mixer_seq.sv
// waveform_mixer_seq: time-multiplexed N-channel mixer with one shared shift-add scaler,
// per-channel gain ramping and a saturating or averaging output stage.
module waveform_mixer_seq #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 8,
    parameter int RAMP_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*WIDTH-1:0]   samples_in,
    input  logic [NUM_CH*8-1:0]       gains_in,
    input  logic                      mix_mode,
    input  logic                      sample_valid,
    output logic                      busy,
    output logic [WIDTH-1:0]          mixed_out,
    output logic                      out_valid,
    output logic                      overrun
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = WIDTH + CW + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    state_t state, next_state;

    logic [NUM_CH*WIDTH-1:0] samples_q;
    logic [NUM_CH*8-1:0]     gains_q;
    logic                    mode_q;
    logic [CW-1:0]           ch;
    logic [AW-1:0]           acc;
    logic [3:0]              lvl [NUM_CH];

    logic [WIDTH-1:0]   smp;
    logic [7:0]         gain;
    logic [3:0]         tgt, cur, nxt;
    logic [WIDTH+3:0]   ext, prod;
    logic [WIDTH:0]     scaled;
    logic [AW-1:0]      avg;
    logic [WIDTH-1:0]   sat, result;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state == IDLE  ? (sample_valid ? ACCUM : IDLE) :
                     state == ACCUM ? (ch == CW'(NUM_CH - 1) ? OUTPUT : ACCUM) : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
    end

    // Level update happens before scaling so the new level applies to this frame.
    always_comb begin
        smp    = samples_q[ch*WIDTH +: WIDTH];
        gain   = gains_q[ch*8 +: 8];
        tgt    = gain == 8'd0 ? 4'd0 : {1'b0, gain[7:5]} + 4'd1;
        cur    = lvl[ch];
        nxt    = RAMP_EN == 0 ? tgt : cur < tgt ? cur + 4'd1 : cur > tgt ? cur - 4'd1 : cur;
        ext    = {4'b0, smp};
        prod   = (nxt[0] ? ext : '0) + (nxt[1] ? ext << 1 : '0) +
                 (nxt[2] ? ext << 2 : '0) + (nxt[3] ? ext << 3 : '0);
        scaled = prod[WIDTH+3:3];
        avg    = acc >> CW;
        sat    = acc > AW'((1 << WIDTH) - 1) ? '1 : acc[WIDTH-1:0];
        result = mode_q ? avg[WIDTH-1:0] : sat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samples_q <= '0;
            gains_q   <= '0;
            mode_q    <= 1'b0;
            ch        <= '0;
            acc       <= '0;
            mixed_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) lvl[i] <= '0;
        end else begin
            out_valid <= state == OUTPUT;
            overrun   <= sample_valid && state != IDLE;
            if (state == IDLE && sample_valid) begin
                samples_q <= samples_in;
                gains_q   <= gains_in;
                mode_q    <= mix_mode;
                ch        <= '0;
                acc       <= '0;
            end
            if (state == ACCUM) begin
                lvl[ch] <= nxt;
                acc     <= acc + AW'(scaled);
                ch      <= ch + CW'(1);
            end
            if (state == OUTPUT) mixed_out <= result;
        end
    end
endmodule
